// File: rtl/simmem_pkg.sv
// Shared types and defaults for the simulated-memory response path.
// Used by the release scheduler and the linked-list response bank.
package simmem_pkg;

  localparam int unsigned DefIdWidth     = 8;
  localparam int unsigned DefNumSlots    = 16;
  localparam int unsigned DefDelayCycles = 10;
  localparam int unsigned NumIds         = 2 ** DefIdWidth;

  typedef logic [DefIdWidth-1:0] id_t;
  typedef logic [NumIds-1:0]     release_t;

  function automatic int unsigned max1(input int unsigned w);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/simmem_slot_alloc.sv
// Lowest-index free slot finder for the release scheduler.
// Produces a one-hot, its binary index and an any-free flag.
module simmem_slot_alloc
  import simmem_pkg::*;
#(
  parameter int unsigned NumSlots = DefNumSlots,
  parameter int unsigned IdxW     = max1($clog2(NumSlots))
) (
  input  logic [NumSlots-1:0] valid_i,
  output logic [NumSlots-1:0] free_oh_o,
  output logic [IdxW-1:0]     free_idx_o,
  output logic                any_free_o
);

  // scan from the top so the lowest free slot wins
  always_comb begin
    free_oh_o  = '0;
    free_idx_o = '0;
    for (int i = NumSlots - 1; i >= 0; i--) begin
      if (!valid_i[i]) begin
        free_oh_o    = '0;
        free_oh_o[i] = 1'b1;
        free_idx_o   = IdxW'(i);
      end
    end
    any_free_o = ~&valid_i;
  end

endmodule

// File: rtl/simmem_release_scheduler.sv
// Per-ID release scheduler: delays each request ID by a fixed
// latency, then holds release_en_o[id] while credits remain.
module simmem_release_scheduler
  import simmem_pkg::*;
#(
  parameter int unsigned IDWidth     = DefIdWidth,
  parameter int unsigned NumSlots    = DefNumSlots,
  parameter int unsigned DelayCycles = DefDelayCycles
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [IDWidth-1:0]    req_id_i,
  input  logic                  rsp_valid_i,
  input  logic [IDWidth-1:0]    rsp_id_i,
  output logic [2**IDWidth-1:0] release_en_o
);

  localparam int unsigned NIds = 2 ** IDWidth;
  localparam int unsigned CntW = max1($clog2(DelayCycles));
  localparam int unsigned OutW = $clog2(NumSlots + 1);
  localparam int unsigned IdxW = max1($clog2(NumSlots));
  localparam logic [CntW-1:0] CntLoad = CntW'(DelayCycles - 1);
  localparam logic [OutW-1:0] OutMax  = OutW'(NumSlots);

  logic [OutW-1:0]                  r_outstanding;
  logic                             w_accept;
  logic                             w_rsp_ok;
  logic [NumSlots-1:0]              w_slot_valid;
  logic [NumSlots-1:0]              w_mat;
  logic [NumSlots-1:0][IDWidth-1:0] w_slot_id;
  logic [NumSlots-1:0]              w_free_oh;
  logic [IdxW-1:0]                  w_free_idx;
  logic                             w_any_free;
  logic                             w_mat_any;
  logic [IDWidth-1:0]               w_mat_id;
  logic [NIds-1:0]                  w_nz;

  assign w_accept     = req_valid_i && req_ready_o;
  assign w_rsp_ok     = rsp_valid_i && w_nz[rsp_id_i];
  assign req_ready_o  = (r_outstanding < OutMax);
  assign release_en_o = w_nz;

  simmem_slot_alloc #(
    .NumSlots(NumSlots),
    .IdxW    (IdxW)
  ) u_alloc (
    .valid_i   (w_slot_valid),
    .free_oh_o (w_free_oh),
    .free_idx_o(w_free_idx),
    .any_free_o(w_any_free)
  );

  for (genvar s = 0; s < NumSlots; s++) begin : g_slot
    logic               r_valid;
    logic [IDWidth-1:0] r_id;
    logic [CntW-1:0]    r_cnt;
    logic               w_load;

    assign w_load = w_accept && w_any_free &&
                    (w_free_idx == IdxW'(s));

    // load on allocate, else count down and free once matured
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_valid <= 1'b0;
        r_id    <= '0;
        r_cnt   <= '0;
      end else if (w_load) begin
        r_valid <= 1'b1;
        r_id    <= req_id_i;
        r_cnt   <= CntLoad;
      end else if (r_valid) begin
        if (r_cnt == '0) r_valid <= 1'b0;
        else             r_cnt   <= r_cnt - 1'b1;
      end
    end

    assign w_slot_valid[s] = r_valid;
    assign w_mat[s]        = r_valid && (r_cnt == '0);
    assign w_slot_id[s]    = r_id;
  end

  // at most one slot matures per cycle, so an OR-mux suffices
  always_comb begin
    w_mat_id = '0;
    for (int s = 0; s < NumSlots; s++) begin
      if (w_mat[s]) w_mat_id = w_mat_id | w_slot_id[s];
    end
  end

  assign w_mat_any = |w_mat;

  for (genvar i = 0; i < NIds; i++) begin : g_cred
    logic [OutW-1:0] r_credit;
    logic            w_inc;
    logic            w_dec;

    assign w_inc = w_mat_any && (w_mat_id == IDWidth'(i));
    assign w_dec = w_rsp_ok && (rsp_id_i == IDWidth'(i));

    // matured-but-unconsumed responses for this ID
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)             r_credit <= '0;
      else if (w_inc && !w_dec) r_credit <= r_credit + 1'b1;
      else if (!w_inc && w_dec) r_credit <= r_credit - 1'b1;
    end

    assign w_nz[i] = (r_credit != '0);
  end

  // slots in flight plus credits not yet consumed
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                   r_outstanding <= '0;
    else if (w_accept && !w_rsp_ok) r_outstanding <= r_outstanding + 1'b1;
    else if (!w_accept && w_rsp_ok) r_outstanding <= r_outstanding - 1'b1;
  end

  // protocol and structural invariants
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert ($onehot0(w_mat))
        else $error("simmem: more than one slot matured");
      if (w_accept) begin
        assert (w_any_free &&
                w_free_oh == (NumSlots'(1) << w_free_idx))
          else $error("simmem: accept without a free slot");
      end
      if (rsp_valid_i) begin
        assert (w_nz[rsp_id_i])
          else $warning("simmem: response on id without credit");
      end
    end
  end

endmodule

// File: tb/tb_simmem_release_scheduler.sv
// Scoreboard bench for simmem_release_scheduler.
// Time-based reference model; monitor compares every cycle.
module tb_simmem_release_scheduler;
  import simmem_pkg::*;

  localparam int D  = 10;
  localparam int NS = 16;
  localparam int NI = 256;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [7:0]    req_id = '0;
  logic          rsp_valid = 1'b0;
  logic [7:0]    rsp_id = '0;
  logic [NI-1:0] rel;

  simmem_release_scheduler #(
    .IDWidth    (8),
    .NumSlots   (NS),
    .DelayCycles(D)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_id_i    (req_id),
    .rsp_valid_i (rsp_valid),
    .rsp_id_i    (rsp_id),
    .release_en_o(rel)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int            tag;
    logic [NI-1:0] rel;
    logic          rdy;
  } exp_t;

  typedef struct {
    int mc;
    int id;
  } pend_t;

  exp_t  q[$];
  pend_t pend[$];
  int    credit[NI];
  int    outst;
  int    errors = 0;
  int    checks = 0;
  bit    mon_en = 1'b0;

  task automatic chk(input string name, input logic [NI-1:0] act,
                     input logic [NI-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, req);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < NI; i++) credit[i] = 0;
    outst = 0;
    pend.delete();
  endfunction

  function automatic exp_t snap(input int tag);
    exp_t e;
    e.tag = tag;
    e.rdy = (outst < NS);
    for (int i = 0; i < NI; i++) e.rel[i] = (credit[i] > 0);
    return e;
  endfunction

  // drive one cycle and predict the state seen in the next one
  task automatic step(input bit v, input int id, input bit rv, input int rid);
    bit acc, ok;
    @(posedge clk);
    #1;
    req_valid = v;
    req_id    = id[7:0];
    rsp_valid = rv;
    rsp_id    = rid[7:0];
    acc = v && (outst < NS);
    ok  = rv && (credit[rid] > 0);
    if (ok) begin
      credit[rid]--;
      outst--;
    end
    while (pend.size() > 0 && pend[0].mc == cyc + 1) begin
      credit[pend[0].id]++;
      void'(pend.pop_front());
    end
    if (acc) begin
      pend.push_back('{cyc + D + 1, id});
      outst++;
    end
    q.push_back(snap(cyc + 1));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0);
  endtask

  // monitor: compare whatever the DUT shows against the queued prediction
  always @(negedge clk) begin
    if (mon_en) begin
      if (q.size() > 0 && q[0].tag < cyc) begin
        errors++;
        checks++;
        $display("FAIL stale_expect cyc=%0d tag=%0d", cyc, q[0].tag);
        void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].tag == cyc) begin
        exp_t e;
        e = q.pop_front();
        chk("release_en", rel, e.rel);
        chk("req_ready", NI'(req_ready), NI'(e.rdy));
      end
    end
  end

  initial begin
    int ids[$];
    int rid;
    model_clear();
    repeat (3) @(posedge clk);
    #3 rst_ni = 1'b1;
    #1 q.push_back(snap(cyc));
    mon_en = 1'b1;

    // single request, release, consume
    idle(4);
    step(1, 3, 0, 0);
    idle(14);
    step(0, 0, 1, 3);
    idle(3);

    // three back-to-back requests on one ID
    for (int k = 0; k < 3; k++) step(1, 7, 0, 0);
    idle(12);
    for (int k = 0; k < 3; k++) step(0, 0, 1, 7);
    idle(2);

    // fill all slots, try an extra, then free one
    for (int k = 0; k < NS; k++) step(1, 16 + k, 0, 0);
    step(1, 50, 0, 0);
    idle(12);
    step(0, 0, 1, 16);
    step(1, 60, 0, 0);
    idle(12);
    for (int k = 1; k < NS; k++) step(0, 0, 1, 16 + k);
    step(0, 0, 1, 60);
    idle(2);

    // maturity and consume of the same ID in one cycle
    step(1, 2, 0, 0);
    step(1, 2, 0, 0);
    idle(9);
    step(0, 0, 1, 2);
    idle(2);
    step(0, 0, 1, 2);
    idle(2);

    // response on an ID without credit
    step(1, 4, 0, 0);
    idle(12);
    step(0, 0, 1, 9);
    idle(2);
    step(0, 0, 1, 4);
    idle(2);

    // randomized traffic
    for (int k = 0; k < 1500; k++) begin
      ids.delete();
      for (int i = 0; i < 8; i++) if (credit[i] > 0) ids.push_back(i);
      rid = 0;
      if (ids.size() > 0 && $urandom_range(0, 9) < 4)
        rid = ids[$urandom_range(0, ids.size() - 1)];
      else if ($urandom_range(0, 49) == 0)
        rid = $urandom_range(8, 255);
      step(1'($urandom_range(0, 1)), $urandom_range(0, 7),
           (rid != 0) || (credit[0] > 0 && $urandom_range(0, 3) == 0),
           rid);
    end
    idle(D + 2);
    for (int i = 0; i < 8; i++) begin
      while (credit[i] > 0) step(0, 0, 1, i);
    end
    idle(2);

    // asynchronous reset with credits held and five slots busy
    step(1, 5, 0, 0);
    step(1, 5, 0, 0);
    idle(12);
    for (int k = 1; k <= 5; k++) step(1, k, 0, 0);
    idle(3);
    @(posedge clk);
    #3 rst_ni = 1'b0;
    mon_en = 1'b0;
    #1 chk("async_rst_release", rel, '0);
    q.delete();
    model_clear();
    repeat (2) @(posedge clk);
    #3 rst_ni = 1'b1;
    #1 chk("post_rst_ready", NI'(req_ready), NI'(1));
    chk("post_rst_release", rel, '0);
    q.push_back(snap(cyc));
    mon_en = 1'b1;
    idle(30);
    step(1, 11, 0, 0);
    idle(D + 2);
    step(0, 0, 1, 11);
    idle(3);

    @(posedge clk);
    @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
